// File: rtl/rob_retire_pkg.sv
// rob_retire_pkg: shared types and sizes for the in-order reorder buffer.
//   ROB_SZ      number of entries (power of two, >= 4)
//   IDX_W       entry index width, derived from ROB_SZ
//   CNT_W       occupancy counter width (IDX_W+1 so that "full" is representable)
//   TAG_W/tag_t physical register tag
//   rob_entry_t per-entry storage {valid, done, t, t_old}, reusable by RS/debug
package rob_retire_pkg;

  localparam int ROB_SZ = 32;
  localparam int IDX_W  = $clog2(ROB_SZ);
  localparam int CNT_W  = IDX_W + 1;
  localparam int TAG_W  = 6;

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [IDX_W-1:0] rob_idx_t;
  typedef logic [CNT_W-1:0] rob_cnt_t;

  typedef struct packed {
    logic valid;
    logic done;
    tag_t t;
    tag_t t_old;
  } rob_entry_t;

endpackage

// File: rtl/rob_retire_if.sv
// rob_retire_if: groups the dispatch, completion and retirement signals of the
// reorder buffer.
//   master modport : dispatch/CDB side (drives dispatch_*, complete_*, squash_en),
//                    observes tail index, full/empty, retirement and count.
//   slave modport  : the reorder buffer itself.
//   count          : registered occupancy, exported for observation/debug.
// Optional macro ROB_SQUASH_EN adds the squash_en flush request.
//
// Handshake semantics: dispatch_en is a request that is accepted on a rising
// edge only when full was low during that cycle; there is no back-pressure other
// than full. complete_en and retire_en are single-cycle strobes with no ready.
interface rob_retire_if;
  import rob_retire_pkg::*;

  logic     dispatch_en;
  tag_t     dispatch_t;
  tag_t     dispatch_t_old;
  rob_idx_t dispatch_idx;
  logic     full;
  logic     empty;
  logic     complete_en;
  rob_idx_t complete_idx;
  logic     retire_en;
  tag_t     retire_t;
  tag_t     retire_t_old;
  rob_cnt_t count;
`ifdef ROB_SQUASH_EN
  logic     squash_en;
`endif

  modport master (
`ifdef ROB_SQUASH_EN
    output squash_en,
`endif
    output dispatch_en, dispatch_t, dispatch_t_old, complete_en, complete_idx,
    input  dispatch_idx, full, empty, retire_en, retire_t, retire_t_old, count
  );

  modport slave (
`ifdef ROB_SQUASH_EN
    input  squash_en,
`endif
    input  dispatch_en, dispatch_t, dispatch_t_old, complete_en, complete_idx,
    output dispatch_idx, full, empty, retire_en, retire_t, retire_t_old, count
  );

endinterface

// File: rtl/rob_retire.sv
// rob_retire: in-order reorder buffer for the R10K pipeline.
// Accepts one dispatched instruction per cycle at the tail, marks entries
// complete out of order from the CDB, and retires the oldest entry once it is
// complete, driving retire_t/retire_t_old/retire_en toward arch_map and the
// free list.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   rob          : rob_retire_if.slave (dispatch, complete, retire, status, count)
// Optional macro ROB_SQUASH_EN: adds squash_en, which flushes the whole buffer
// (highest priority after reset, blocks retirement combinationally).
module rob_retire
  import rob_retire_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  rob_retire_if.slave  rob
);

  localparam rob_idx_t IDX_ONE = rob_idx_t'(1);
  localparam rob_cnt_t CNT_ONE = rob_cnt_t'(1);
  localparam rob_cnt_t CNT_MAX = rob_cnt_t'(ROB_SZ);

  rob_entry_t [ROB_SZ-1:0] entries;
  rob_idx_t                head;
  rob_idx_t                tail;
  rob_cnt_t                count;

  logic       squash;
  logic       full;
  logic       dispatch_acc;
  logic       retire_fire;
  rob_entry_t head_entry;

`ifdef ROB_SQUASH_EN
  assign squash = rob.squash_en;
`else
  assign squash = 1'b0;
`endif

  // Status is decoded from registered state only, so a retire in the same
  // cycle cannot unblock a dispatch.
  assign full         = (count == CNT_MAX);
  assign dispatch_acc = rob.dispatch_en && !full;

  assign head_entry  = entries[head];
  // Reset and squash gate retirement immediately, not just at the next edge.
  assign retire_fire = head_entry.valid && head_entry.done && !reset && !squash;

  assign rob.retire_en    = retire_fire;
  assign rob.retire_t     = retire_fire ? head_entry.t     : '0;
  assign rob.retire_t_old = retire_fire ? head_entry.t_old : '0;
  assign rob.full         = full;
  assign rob.empty        = (count == '0);
  assign rob.dispatch_idx = tail;
  assign rob.count        = count;

  always_ff @(posedge clock) begin
    if (reset || squash) begin
      entries <= '0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
    end else begin
      // Completion first: if the same entry also retires this edge, the
      // retire clear below takes precedence. Invalid or already-done
      // targets are harmless no-ops.
      if (rob.complete_en && entries[rob.complete_idx].valid) begin
        entries[rob.complete_idx].done <= 1'b1;
      end
      if (retire_fire) begin
        entries[head].valid <= 1'b0;
        entries[head].done  <= 1'b0;
        head                <= head + IDX_ONE;
      end
      // When not full, tail only equals head if the buffer is empty, so the
      // allocation never collides with a retiring entry.
      if (dispatch_acc) begin
        entries[tail] <= '{valid: 1'b1, done: 1'b0,
                           t: rob.dispatch_t, t_old: rob.dispatch_t_old};
        tail          <= tail + IDX_ONE;
      end
      unique case ({dispatch_acc, retire_fire})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_no_dispatch_when_full : assert property (@(posedge clock) disable iff (reset)
    !(dispatch_acc && full));
  a_count_bound : assert property (@(posedge clock) disable iff (reset)
    count <= CNT_MAX);
  a_no_complete_on_new_entry : assert property (@(posedge clock) disable iff (reset || squash)
    !(rob.complete_en && dispatch_acc && (rob.complete_idx == tail)));
`endif

endmodule

// File: tb/tb_rob_retire.sv
// tb_rob_retire: directed bench for rob_retire. Expected retirements are pushed
// into exp_q when a dispatch is issued; a negedge monitor pops and compares on
// every retire_en. Status outputs are checked directly against hand values.
module tb_rob_retire;
  import rob_retire_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  rob_retire_if rif();

  rob_retire dut (
    .clock (clock),
    .reset (reset),
    .rob   (rif)
  );

  // ---------------- scoreboard state ----------------
  logic [2*TAG_W-1:0] exp_q[$];
  int               n_vec = 0;
  int               n_err = 0;
  rob_idx_t         exp_idx;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic dispatch(input tag_t t, input tag_t t_old, input bit expect_retire);
    rif.dispatch_en    = 1'b1;
    rif.dispatch_t     = t;
    rif.dispatch_t_old = t_old;
    if (expect_retire) exp_q.push_back({t, t_old});
    exp_idx = exp_idx + IDX_W'(1);
    step();
    rif.dispatch_en = 1'b0;
  endtask

  task automatic complete(input rob_idx_t idx);
    rif.complete_en  = 1'b1;
    rif.complete_idx = idx;
    step();
    rif.complete_en = 1'b0;
  endtask

  task automatic wait_empty(input int max_cyc);
    int c;
    c = 0;
    while (rif.empty !== 1'b1 && c < max_cyc) begin
      step();
      c++;
    end
    check("drain_empty", 32'(rif.empty), 32'd1);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (rif.retire_en === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL retire_unexpected: got t=%0d t_old=%0d, expected no retire",
                 rif.retire_t, rif.retire_t_old);
      end else begin
        logic [2*TAG_W-1:0] e;
        e = exp_q.pop_front();
        if ({rif.retire_t, rif.retire_t_old} !== e) begin
          n_err++;
          $display("FAIL retire_order: got t=%0d t_old=%0d, expected t=%0d t_old=%0d",
                   rif.retire_t, rif.retire_t_old, e[2*TAG_W-1:TAG_W], e[TAG_W-1:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    rob_idx_t b;
    reset              = 1'b1;
    rif.dispatch_en    = 1'b0;
    rif.dispatch_t     = '0;
    rif.dispatch_t_old = '0;
    rif.complete_en    = 1'b0;
    rif.complete_idx   = '0;
`ifdef ROB_SQUASH_EN
    rif.squash_en      = 1'b0;
`endif
    exp_idx = '0;

    // 1: reset held two cycles
    step();
    step();
    check("reset_empty",     32'(rif.empty),        32'd1);
    check("reset_full",      32'(rif.full),         32'd0);
    check("reset_retire_en", 32'(rif.retire_en),    32'd0);
    check("reset_idx",       32'(rif.dispatch_idx), 32'd0);
    check("reset_count",     32'(rif.count),        32'd0);
    reset = 1'b0;

    // 2: out-of-order completion, in-order retirement
    dispatch(6'd33, 6'd1, 1'b1);
    dispatch(6'd34, 6'd2, 1'b1);
    dispatch(6'd35, 6'd3, 1'b1);
    check("basic_count", 32'(rif.count),        32'd3);
    check("basic_idx",   32'(rif.dispatch_idx), 32'd3);
    complete(5'd2);
    check("no_retire_before_head", 32'(rif.retire_en), 32'd0);
    complete(5'd0);
    check("retire_latency", 32'(rif.retire_en), 32'd1);
    check("retire_t_head",  32'(rif.retire_t),  32'd33);
    complete(5'd1);
    wait_empty(10);
    check("basic_drained", 32'(exp_q.size()), 32'd0);

    // 3/4: fill to full with wrap of the tail pointer
    for (int i = 0; i < ROB_SZ; i++) begin
      check("fill_idx", 32'(rif.dispatch_idx), 32'(exp_idx));
      dispatch(tag_t'(i + 16), tag_t'(i), 1'b1);
    end
    check("full_flag",  32'(rif.full),         32'd1);
    check("full_count", 32'(rif.count),        32'd32);
    check("full_idx",   32'(rif.dispatch_idx), 32'd3);
    // dispatch while full is ignored
    rif.dispatch_en    = 1'b1;
    rif.dispatch_t     = 6'd60;
    rif.dispatch_t_old = 6'd60;
    step();
    rif.dispatch_en = 1'b0;
    check("full_ignore_count", 32'(rif.count),        32'd32);
    check("full_ignore_idx",   32'(rif.dispatch_idx), 32'd3);
    // retire head; a dispatch in the retire cycle is still blocked
    complete(5'd3);
    check("full_retire_en", 32'(rif.retire_en), 32'd1);
    rif.dispatch_en    = 1'b1;
    rif.dispatch_t     = 6'd61;
    rif.dispatch_t_old = 6'd61;
    step();
    rif.dispatch_en = 1'b0;
    check("retire_no_unblock_count", 32'(rif.count),        32'd31);
    check("retire_no_unblock_idx",   32'(rif.dispatch_idx), 32'd3);
    check("after_retire_full",       32'(rif.full),         32'd0);
    dispatch(6'd50, 6'd51, 1'b1);
    check("refill_count", 32'(rif.count),        32'd32);
    check("refill_idx",   32'(rif.dispatch_idx), 32'd4);
    // complete youngest first so everything waits on the head
    for (int i = ROB_SZ - 1; i >= 0; i--) complete(rob_idx_t'(int'(exp_idx) + i));
    wait_empty(40);
    check("wrap_drained", 32'(exp_q.size()), 32'd0);

    // 5: simultaneous dispatch and retire at count 5
    b = exp_idx;
    for (int i = 0; i < 5; i++) dispatch(tag_t'(40 + i), tag_t'(20 + i), 1'b1);
    complete(b);
    check("sim_retire_en", 32'(rif.retire_en), 32'd1);
    check("sim_pre_count", 32'(rif.count),     32'd5);
    dispatch(6'd45, 6'd25, 1'b1);
    check("sim_count", 32'(rif.count),        32'd5);
    check("sim_idx",   32'(rif.dispatch_idx), 32'(b + 5'd6));
    for (int i = 1; i < 6; i++) complete(rob_idx_t'(int'(b) + i));
    wait_empty(10);

`ifdef ROB_SQUASH_EN
    // 6: squash with two entries done, head retire pending
    b = exp_idx;
    for (int i = 0; i < 4; i++) dispatch(tag_t'(8 + i), tag_t'(12 + i), 1'b0);
    complete(rob_idx_t'(int'(b) + 2));
    complete(b);
    rif.squash_en    = 1'b1;
    rif.dispatch_en  = 1'b1;
    rif.complete_en  = 1'b1;
    rif.complete_idx = rob_idx_t'(int'(b) + 1);
    #1;
    check("squash_blocks_retire", 32'(rif.retire_en), 32'd0);
    step();
    rif.squash_en   = 1'b0;
    rif.dispatch_en = 1'b0;
    rif.complete_en = 1'b0;
    check("squash_empty", 32'(rif.empty),        32'd1);
    check("squash_idx",   32'(rif.dispatch_idx), 32'd0);
    check("squash_count", 32'(rif.count),        32'd0);
    exp_idx = '0;
    dispatch(6'd7, 6'd9, 1'b1);
    complete(5'd0);
    wait_empty(5);
`endif

    // reset during a pending retire: nothing retires, buffer discarded
    b = exp_idx;
    dispatch(6'd30, 6'd31, 1'b0);
    complete(b);
    reset = 1'b1;
    #1;
    check("reset_blocks_retire", 32'(rif.retire_en), 32'd0);
    step();
    reset = 1'b0;
    exp_idx = '0;
    check("midreset_empty", 32'(rif.empty),        32'd1);
    check("midreset_idx",   32'(rif.dispatch_idx), 32'd0);

    step();
    step();
    check("scoreboard_leftover", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
